timebase_ctr: RTL and testbench

Parametrised PWM timebase: a prescaler plus a period counter supporting edge-aligned (up-count) and center-aligned (up/down) modes. It adds a run-enable, a period-boundary strobe and double-buffered period/prescale/mode settings. It sits between the APB register file and the PWM channel comparators, driving their shared count and sync strobes.

---
 rtl/timebase_ctr.sv | 128 ++++++++++++
 tb/tb_timebase_ctr.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/timebase_ctr.sv
// timebase_ctr: PWM timebase made of a prescaler and a period counter.
// The period counter runs edge-aligned (up-count, wrap to 0) or
// center-aligned (up/down). sync_pulse marks each prescale tick and
// period_end marks each period boundary; both are combinational.
//
// Optional feature macro: TIMEBASE_SHADOW_EN
//   defined   - period/prescale/mode are shadowed in registers that load at
//               a period boundary or while the timebase is disabled.
//   undefined - period/prescale/mode come straight from the inputs.
module timebase_ctr #(
  parameter int APB_DWIDTH = 8
) (
  input  logic                  PCLK,
  input  logic                  PRESETN,
  input  logic                  enable,
  input  logic                  center_mode,
  input  logic [APB_DWIDTH-1:0] period_reg,
  input  logic [APB_DWIDTH-1:0] prescale_reg,
  output logic [APB_DWIDTH-1:0] period_cnt,
  output logic                  cnt_dir,
  output logic                  sync_pulse,
  output logic                  period_end
);

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  localparam logic [APB_DWIDTH-1:0] ONE = APB_DWIDTH'(1);

  // Active settings used by the counters
  logic [APB_DWIDTH-1:0] p_a;
  logic [APB_DWIDTH-1:0] s_a;
  logic                  m_a;

  logic [APB_DWIDTH-1:0] presc_cnt;
  logic                  presc_wrap;
  logic                  tick;

  dir_e                  dir_q;
  dir_e                  dir_nxt;
  logic [APB_DWIDTH-1:0] cnt_nxt;
  logic                  boundary;

`ifdef TIMEBASE_SHADOW_EN
  // Shadow registers: reload at a period boundary or whenever disabled
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      p_a <= '0;
      s_a <= '0;
      m_a <= 1'b0;
    end else if (period_end || !enable) begin
      p_a <= period_reg;
      s_a <= prescale_reg;
      m_a <= center_mode;
    end
  end
`else
  assign p_a = period_reg;
  assign s_a = prescale_reg;
  assign m_a = center_mode;
`endif

  // >= (not ==) so a prescale value lowered below the count still wraps
  assign presc_wrap = (presc_cnt >= s_a);
  assign tick       = enable & presc_wrap;

  // Prescaler: wraps to 0 at S_a, frozen while disabled
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      presc_cnt <= '0;
    end else if (enable) begin
      presc_cnt <= presc_wrap ? '0 : presc_cnt + ONE;
    end
  end

  // Next period count, direction and boundary flag for the current tick
  always_comb begin
    cnt_nxt  = period_cnt;
    dir_nxt  = dir_q;
    boundary = 1'b0;
    if (!m_a) begin
      dir_nxt = DIR_UP;
      if (period_cnt >= p_a) begin
        cnt_nxt  = '0;
        boundary = 1'b1;
      end else begin
        cnt_nxt = period_cnt + ONE;
      end
    end else if (p_a == '0) begin
      cnt_nxt  = '0;
      dir_nxt  = DIR_UP;
      boundary = 1'b1;
    end else if (dir_q == DIR_UP) begin
      if (period_cnt >= p_a) begin
        cnt_nxt = p_a - ONE;
        dir_nxt = DIR_DOWN;
      end else begin
        cnt_nxt = period_cnt + ONE;
      end
    end else begin
      if (period_cnt == '0) begin
        cnt_nxt  = ONE;
        dir_nxt  = DIR_UP;
        boundary = 1'b1;
      end else begin
        cnt_nxt = period_cnt - ONE;
      end
    end
  end

  // Period counter and direction advance only on a prescale tick
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      period_cnt <= '0;
      dir_q      <= DIR_UP;
    end else if (tick) begin
      period_cnt <= cnt_nxt;
      dir_q      <= dir_nxt;
    end
  end

  assign cnt_dir    = dir_q;
  assign sync_pulse = tick;
  assign period_end = tick & boundary;

endmodule

// File: tb/tb_timebase_ctr.sv
// Self-checking bench for timebase_ctr. A cycle model of the timebase and
// directed constant sequences push expected outputs into a scoreboard queue
// as each cycle's stimulus is driven; the monitor pops and compares on the
// falling edge. Works with TIMEBASE_SHADOW_EN defined or undefined.
module tb_timebase_ctr;

  localparam int W = 8;

  logic         PCLK = 1'b0;
  logic         PRESETN = 1'b0;
  logic         enable = 1'b0;
  logic         center_mode = 1'b0;
  logic [W-1:0] period_reg = '0;
  logic [W-1:0] prescale_reg = '0;
  logic [W-1:0] period_cnt;
  logic         cnt_dir;
  logic         sync_pulse;
  logic         period_end;

  timebase_ctr #(.APB_DWIDTH(W)) dut (
    .PCLK        (PCLK),
    .PRESETN     (PRESETN),
    .enable      (enable),
    .center_mode (center_mode),
    .period_reg  (period_reg),
    .prescale_reg(prescale_reg),
    .period_cnt  (period_cnt),
    .cnt_dir     (cnt_dir),
    .sync_pulse  (sync_pulse),
    .period_end  (period_end)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    int unsigned cnt;
    bit          dir;
    bit          sync;
    bit          pe;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state
  int unsigned m_presc, m_cnt;
  bit          m_dir;
`ifdef TIMEBASE_SHADOW_EN
  int unsigned m_pa, m_sa;
  bit          m_ma;
`endif

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_presc = 0;
    m_cnt   = 0;
    m_dir   = 1'b1;
`ifdef TIMEBASE_SHADOW_EN
    m_pa = 0;
    m_sa = 0;
    m_ma = 1'b0;
`endif
  endtask

  // Outputs for this cycle, then state after the next rising edge
  task automatic model_step(input bit en, input bit cm, input int unsigned p,
                            input int unsigned s, output exp_t e);
    int unsigned pa, sa, ncnt;
    bit ma, tk, bnd, ndir;
`ifdef TIMEBASE_SHADOW_EN
    pa = m_pa; sa = m_sa; ma = m_ma;
`else
    pa = p; sa = s; ma = cm;
`endif
    tk   = en && (m_presc >= sa);
    ncnt = m_cnt;
    ndir = m_dir;
    bnd  = 1'b0;
    if (!ma) begin
      ndir = 1'b1;
      if (m_cnt >= pa) begin ncnt = 0; bnd = 1'b1; end
      else ncnt = m_cnt + 1;
    end else if (pa == 0) begin
      ncnt = 0; ndir = 1'b1; bnd = 1'b1;
    end else if (m_dir) begin
      if (m_cnt >= pa) begin ncnt = pa - 1; ndir = 1'b0; end
      else ncnt = m_cnt + 1;
    end else if (m_cnt == 0) begin
      ncnt = 1; ndir = 1'b1; bnd = 1'b1;
    end else begin
      ncnt = m_cnt - 1;
    end
    e.cnt  = m_cnt;
    e.dir  = m_dir;
    e.sync = tk;
    e.pe   = tk && bnd;
    if (en) m_presc = (m_presc >= sa) ? 0 : m_presc + 1;
    if (tk) begin m_cnt = ncnt; m_dir = ndir; end
`ifdef TIMEBASE_SHADOW_EN
    if (e.pe || !en) begin m_pa = p; m_sa = s; m_ma = cm; end
`endif
  endtask

  task automatic apply(input bit en, input bit cm, input int unsigned p, input int unsigned s);
    @(posedge PCLK);
    #1;
    PRESETN      = 1'b1;
    enable       = en;
    center_mode  = cm;
    period_reg   = W'(p);
    prescale_reg = W'(s);
  endtask

  task automatic drive(input bit en, input bit cm, input int unsigned p, input int unsigned s);
    exp_t e;
    apply(en, cm, p, s);
    model_step(en, cm, p, s, e);
    sb_q.push_back(e);
  endtask

  // Same as drive, but the expectation is a constant from the scenario
  task automatic drive_fix(input bit en, input bit cm, input int unsigned p, input int unsigned s,
                           input int unsigned c, input bit d, input bit sy, input bit pe);
    exp_t e;
    apply(en, cm, p, s);
    model_step(en, cm, p, s, e);
    e.cnt = c; e.dir = d; e.sync = sy; e.pe = pe;
    sb_q.push_back(e);
  endtask

  always @(negedge PCLK) begin : monitor
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val("period_cnt", 32'(period_cnt), 32'(e.cnt));
      check_val("cnt_dir",    32'(cnt_dir),    32'(e.dir));
      check_val("sync_pulse", 32'(sync_pulse), 32'(e.sync));
      check_val("period_end", 32'(period_end), 32'(e.pe));
    end
  end

  int unsigned edge_cnt [16] = '{0,0,1,1,2,2,3,3,0,0,1,1,2,2,3,3};
  int unsigned ctr_cnt  [13] = '{0,1,2,3,2,1,0,1,2,3,2,1,0};
  bit          ctr_dir  [13] = '{1,1,1,1,0,0,0,1,1,1,0,0,0};

  initial begin
    int unsigned rp, rs;
    bit rc;

    // Reset state; strobes follow enable while in reset
    model_reset();
    enable = 1'b1;
    #12;
    check_val("rst_cnt",      32'(period_cnt), 0);
    check_val("rst_dir",      32'(cnt_dir),    1);
    check_val("rst_sync_en1", 32'(sync_pulse), 1);
    check_val("rst_pe_en1",   32'(period_end), 1);
    enable = 1'b0;
    #1;
    check_val("rst_sync_en0", 32'(sync_pulse), 0);
    check_val("rst_pe_en0",   32'(period_end), 0);

    // Edge-aligned P=3 S=1
    drive(1'b0, 1'b0, 3, 1);
    for (int unsigned i = 0; i < 16; i++)
      drive_fix(1'b1, 1'b0, 3, 1, edge_cnt[i], 1'b1, (i % 2) == 1, (i == 7) || (i == 15));

    // Center-aligned P=3 S=0
    drive(1'b0, 1'b1, 3, 0);
    for (int unsigned i = 0; i < 13; i++)
      drive_fix(1'b1, 1'b1, 3, 0, ctr_cnt[i], ctr_dir[i], 1'b1, (i == 6) || (i == 12));

    // Enable gating at cnt=2: everything frozen for 5 cycles
    drive(1'b0, 1'b0, 5, 1);
    for (int unsigned i = 0; i < 40 && m_cnt != 2; i++) drive(1'b1, 1'b0, 5, 1);
    for (int unsigned i = 0; i < 5; i++) drive_fix(1'b0, 1'b0, 5, 1, 2, 1'b1, 1'b0, 1'b0);
    for (int unsigned i = 0; i < 12; i++) drive(1'b1, 1'b0, 5, 1);

    // Period lowered from 7 to 2 while cnt=3
    drive(1'b0, 1'b0, 7, 0);
    for (int unsigned i = 0; i < 40 && m_cnt != 3; i++) drive(1'b1, 1'b0, 7, 0);
`ifdef TIMEBASE_SHADOW_EN
    drive_fix(1'b1, 1'b0, 2, 0, 3, 1'b1, 1'b1, 1'b0);
    drive_fix(1'b1, 1'b0, 2, 0, 4, 1'b1, 1'b1, 1'b0);
`else
    drive_fix(1'b1, 1'b0, 2, 0, 3, 1'b1, 1'b1, 1'b1);
    drive_fix(1'b1, 1'b0, 2, 0, 0, 1'b1, 1'b1, 1'b0);
`endif
    for (int unsigned i = 0; i < 14; i++) drive(1'b1, 1'b0, 2, 0);

    // Center P=0 S=2: count stuck at 0, boundary every tick
    for (int unsigned i = 0; i < 40 && m_cnt != 0; i++) drive(1'b1, 1'b0, 2, 0);
    drive(1'b0, 1'b1, 0, 2);
    for (int unsigned i = 0; i < 12; i++)
      drive_fix(1'b1, 1'b1, 0, 2, 0, 1'b1, (i % 3) == 2, (i % 3) == 2);

    // Random settings, enable mostly on
    rp = 3; rs = 1; rc = 1'b0;
    for (int unsigned i = 0; i < 300; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        rp = $urandom_range(0, 6);
        rs = $urandom_range(0, 3);
        rc = 1'($urandom_range(0, 1));
      end
      drive($urandom_range(0, 7) != 0, rc, rp, rs);
    end

    // Reset asserted mid down-count (cnt=2, dir=0)
    drive(1'b0, 1'b1, 4, 0);
    for (int unsigned i = 0; i < 40 && !(m_cnt == 2 && !m_dir); i++) drive(1'b1, 1'b1, 4, 0);
    @(posedge PCLK);
    #1;
    check_val("pre_rst_cnt", 32'(period_cnt), 2);
    check_val("pre_rst_dir", 32'(cnt_dir),    0);
    PRESETN = 1'b0;
    #1;
    check_val("mid_rst_cnt",  32'(period_cnt), 0);
    check_val("mid_rst_dir",  32'(cnt_dir),    1);
    check_val("mid_rst_sync", 32'(sync_pulse), 1);
    model_reset();
    for (int unsigned i = 0; i < 12; i++) drive(1'b1, 1'b1, 4, 0);

    @(posedge PCLK);
    @(negedge PCLK);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
